// File: rtl/display_pkg.sv
// Shared constants and types for the display time-sharing scheduler.
package display_pkg;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned DATA_W  = 32;

  // Source slots on the packed src_data bus
  localparam logic [1:0] SRC_PC    = 2'd0;
  localparam logic [1:0] SRC_INSTR = 2'd1;
  localparam logic [1:0] SRC_ALU   = 2'd2;
  localparam logic [1:0] SRC_REG   = 2'd3;

  typedef enum logic [0:0] {
    StIdle,
    StHold
  } state_e;

endpackage

// File: rtl/display_scheduler_if.sv
// Bundle of debug-source inputs and display-side outputs of the scheduler.
interface display_scheduler_if;
  import display_pkg::*;

  logic [DATA_W*NUM_SRC-1:0] src_data;
  logic [NUM_SRC-1:0]        src_req;
  logic                      freeze;
  logic                      skip;
  logic [DATA_W-1:0]         data_to_show;
  logic [NUM_SRC-1:0]        grant;
  logic [1:0]                sel;
  logic                      switched;

  // Master drives the sources and controls; slave is the scheduler
  modport master (
    output src_data, src_req, freeze, skip,
    input  data_to_show, grant, sel, switched
  );

  modport slave (
    input  src_data, src_req, freeze, skip,
    output data_to_show, grant, sel, switched
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after `last`, wrapping.
module rr_pick
  import display_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [1:0]         last,
  output logic               any,
  output logic [1:0]         idx,
  output logic [NUM_SRC-1:0] onehot
);

  logic [1:0] cand;

  // Scan last+1 .. last+NUM_SRC; the final step lands on `last` itself
  always_comb begin
    any    = 1'b0;
    idx    = last;
    cand   = '0;
    onehot = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = last + 2'(k);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/display_scheduler.sv
// Time-shares the seven-segment display among up to four debug sources,
// holding each requester for HOLD_CYCLES before rotating round-robin.
module display_scheduler
  import display_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 100_000_000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  display_scheduler_if.slave  bus
);

  state_e             state_q;
  logic [NUM_SRC-1:0] grant_q;
  logic [1:0]         sel_q;
  logic [1:0]         last_q;
  logic [DATA_W-1:0]  data_q;
  logic               switched_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               pick_any;
  logic [1:0]         pick_idx;
  logic [NUM_SRC-1:0] pick_onehot;
  logic               owner_req;
  logic               expired;
  logic               rotate;
  logic [DATA_W-1:0]  owner_word;

  rr_pick u_rr_pick (
    .req    (bus.src_req),
    .last   (last_q),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  assign owner_req  = |(bus.src_req & grant_q);
  assign expired    = (cnt_q == CNT_W'(HOLD_CYCLES - 1));
  // Freeze masks expiry and skip, but a vanished owner always forces rotation
  assign rotate     = !owner_req || (!bus.freeze && (expired || bus.skip));
  assign owner_word = bus.src_data[{sel_q, 5'd0} +: DATA_W];

  // Ownership FSM with registered grant/sel/data/switched outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      sel_q      <= '0;
      last_q     <= 2'(NUM_SRC - 1);
      data_q     <= '0;
      switched_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      switched_q <= 1'b0;
      // Live word of the current owner, one cycle behind; held when unowned
      if (grant_q != '0) data_q <= owner_word;

      unique case (state_q)
        StIdle: begin
          if (pick_any) begin
            grant_q    <= pick_onehot;
            sel_q      <= pick_idx;
            last_q     <= pick_idx;
            cnt_q      <= '0;
            switched_q <= 1'b1;
            state_q    <= StHold;
          end
        end
        StHold: begin
          if (rotate) begin
            cnt_q <= '0;
            if (!pick_any) begin
              grant_q <= '0;
              state_q <= StIdle;
            end else if (pick_idx != sel_q) begin
              grant_q    <= pick_onehot;
              sel_q      <= pick_idx;
              last_q     <= pick_idx;
              switched_q <= 1'b1;
            end
          end else if (!bus.freeze) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.grant        = grant_q;
  assign bus.sel          = sel_q;
  assign bus.data_to_show = data_q;
  assign bus.switched     = switched_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Scoreboard bench for display_scheduler with a short hold period.
module tb_display_scheduler;
  import display_pkg::*;

  localparam int unsigned HOLD = 4;

  typedef struct packed {
    logic [3:0]  grant;
    logic        sw;
    logic [31:0] data;
    logic [1:0]  sel;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  display_scheduler_if bus ();

  display_scheduler #(
    .HOLD_CYCLES (HOLD),
    .CNT_W       (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int          m_owner;
  int          m_last;
  int          m_cnt;
  logic [31:0] m_data;

  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_cnt   = 0;
    m_data  = '0;
  endtask

  function automatic int m_search(input logic [3:0] req);
    for (int k = 1; k <= 4; k++) begin
      if (req[(m_last + k) % 4]) return (m_last + k) % 4;
    end
    return -1;
  endfunction

  // Advance the model by one clock edge and queue the expected outputs
  task automatic model_step(input logic [3:0] req, input logic frz, input logic skp,
                            input logic [127:0] words);
    logic [31:0] nd;
    logic        sw;
    int          w;
    bit          ev;
    obs_t        e;
    nd = (m_owner >= 0) ? words[m_owner*32 +: 32] : m_data;
    sw = 1'b0;
    if (m_owner < 0) begin
      w = m_search(req);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_cnt = 0; sw = 1'b1;
      end
    end else begin
      ev = !req[m_owner] || (!frz && (skp || m_cnt == HOLD - 1));
      if (ev) begin
        w = m_search(req);
        m_cnt = 0;
        if (w < 0) m_owner = -1;
        else begin
          if (w != m_owner) sw = 1'b1;
          m_owner = w;
          m_last  = w;
        end
      end else if (!frz) begin
        m_cnt++;
      end
    end
    m_data  = nd;
    e.grant = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    e.sw    = sw;
    e.data  = nd;
    e.sel   = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    exp_q.push_back(e);
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.grant = bus.grant;
    o.sw    = bus.switched;
    o.data  = bus.data_to_show;
    o.sel   = (bus.grant != '0) ? bus.sel : 2'd0;
    return o;
  endfunction

  task automatic cycle(input logic [3:0] req, input logic frz, input logic skp);
    bus.src_req = req;
    bus.freeze  = frz;
    bus.skip    = skp;
    model_step(req, frz, skp, bus.src_data);
    @(posedge clk);
    #1;
  endtask

  task automatic random_words();
    bus.src_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic test_reset();
    obs_t got;
    bus.src_data = '0; bus.src_req = '0; bus.freeze = 1'b0; bus.skip = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    got = observe();
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h want 0", got);
    end
    // Idle with no requests: nothing should change, even with skip
    for (int i = 0; i < 3; i++) begin
      obs_t e;
      cycle(4'b0000, 1'b0, 1'(i));
      e = exp_q.pop_front(); got = observe(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL idle_skip cyc %0d: got %h want %h", i, got, e);
      end
    end
  endtask

  task automatic test_first_grant();
    obs_t got, e;
    bus.src_data = '0;
    bus.src_data[SRC_PC*32 +: 32]  = 32'h1111_1111;
    bus.src_data[SRC_ALU*32 +: 32] = 32'h2222_2222;
    for (int i = 0; i < 12; i++) begin
      cycle(4'b0101, 1'b0, 1'b0);
      e = exp_q.pop_front(); got = observe(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL first_grant cyc %0d: got %h want %h", i, got, e);
      end
    end
    // Withdraw all requests so the next test starts from idle
    for (int i = 0; i < 2; i++) begin
      cycle(4'b0000, 1'b0, 1'b0);
      e = exp_q.pop_front(); got = observe(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL first_grant_release cyc %0d: got %h want %h", i, got, e);
      end
    end
  endtask

  task automatic test_fairness();
    obs_t got, e;
    int   sw_count = 0;
    for (int i = 0; i < 40; i++) begin
      random_words();
      cycle(4'b1111, 1'b0, 1'b0);
      e = exp_q.pop_front(); got = observe(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL fairness cyc %0d: got %h want %h", i, got, e);
      end
      if (got.sw) sw_count++;
    end
    checks++;
    if (sw_count != 10) begin
      errors++;
      $display("FAIL fairness_switch_count: got %0d want 10", sw_count);
    end
  endtask

  task automatic test_freeze();
    obs_t       got, e;
    logic [3:0] g = '0;
    int         held = 0;
    bit         seen = 0;
    bit         left = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      cycle(4'b1111, 1'b0, 1'b0);
      e = exp_q.pop_front(); got = observe(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL freeze_sync cyc %0d: got %h want %h", i, got, e);
      end
      if (got.sw) begin seen = 1; g = got.grant; held = 1; end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL freeze_sync_timeout: got no switch want switch within 8 cycles");
    end
    cycle(4'b1111, 1'b0, 1'b0);
    e = exp_q.pop_front(); got = observe(); checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL freeze_pre: got %h want %h", got, e);
    end
    if (got.grant == g) held++;
    for (int i = 0; i < 10; i++) begin
      cycle(4'b1111, 1'b1, 1'(i % 2));
      e = exp_q.pop_front(); got = observe(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL freeze_frozen cyc %0d: got %h want %h", i, got, e);
      end
      if (got.grant == g) held++;
    end
    for (int i = 0; i < 20 && !left; i++) begin
      cycle(4'b1111, 1'b0, 1'b0);
      e = exp_q.pop_front(); got = observe(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL freeze_post cyc %0d: got %h want %h", i, got, e);
      end
      if (got.grant == g) held++;
      else left = 1;
    end
    checks++;
    if (held != 14) begin
      errors++;
      $display("FAIL freeze_hold_len: got %0d want 14", held);
    end
  endtask

  task automatic test_owner_drop();
    obs_t        got, e;
    bit          seen = 0;
    logic [31:0] kept;
    random_words();
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(4'b1111, 1'b0, 1'b0);
      e = exp_q.pop_front(); got = observe(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL drop_sync cyc %0d: got %h want %h", i, got, e);
      end
      if (got.grant == 4'b0010) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL drop_sync_timeout: got no grant 0010 want grant within 20 cycles");
    end
    cycle(4'b1111, 1'b0, 1'b0);
    e = exp_q.pop_front(); got = observe(); checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL drop_hold1: got %h want %h", got, e);
    end
    // Owner 1 drops while frozen: source 2 must take over immediately
    cycle(4'b1101, 1'b1, 1'b0);
    e = exp_q.pop_front(); got = observe(); checks++;
    if (got !== e || got.grant !== 4'b0100) begin
      errors++;
      $display("FAIL drop_to_next: got %h want %h (grant 0100)", got, e);
    end
    // Lone requester, then it drops as well: back to idle
    cycle(4'b0010, 1'b0, 1'b0);
    e = exp_q.pop_front(); got = observe(); checks++;
    if (got !== e || got.grant !== 4'b0010) begin
      errors++;
      $display("FAIL drop_lone_grant: got %h want %h (grant 0010)", got, e);
    end
    cycle(4'b0010, 1'b0, 1'b0);
    e = exp_q.pop_front(); got = observe(); checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL drop_lone_hold: got %h want %h", got, e);
    end
    cycle(4'b0000, 1'b1, 1'b0);
    e = exp_q.pop_front(); got = observe(); checks++;
    if (got !== e || got.grant !== 4'b0000) begin
      errors++;
      $display("FAIL drop_to_idle: got %h want %h (grant 0000)", got, e);
    end
    kept = bus.src_data[SRC_INSTR*32 +: 32];
    for (int i = 0; i < 3; i++) begin
      random_words();
      cycle(4'b0000, 1'b0, 1'b0);
      e = exp_q.pop_front(); got = observe(); checks++;
      if (got !== e || got.data !== kept) begin
        errors++;
        $display("FAIL drop_idle_keep cyc %0d: got %h want %h (data %h)", i, got, e, kept);
      end
    end
  endtask

  task automatic test_single();
    obs_t got, e;
    int   sw_count = 0;
    for (int i = 0; i < 20; i++) begin
      random_words();
      cycle(4'b0010, 1'b0, 1'b0);
      e = exp_q.pop_front(); got = observe(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL single cyc %0d: got %h want %h", i, got, e);
      end
      if (got.sw) sw_count++;
    end
    checks++;
    if (sw_count != 1) begin
      errors++;
      $display("FAIL single_switch_count: got %0d want 1", sw_count);
    end
  endtask

  task automatic test_async_reset();
    obs_t got, e;
    random_words();
    for (int i = 0; i < 6; i++) begin
      cycle(4'b1111, 1'b0, 1'b0);
      e = exp_q.pop_front(); got = observe(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL areset_pre cyc %0d: got %h want %h", i, got, e);
      end
    end
    #3 rst = 1'b1;
    #1;
    got = observe(); checks++;
    if (got !== '0 || bus.sel !== 2'd0) begin
      errors++;
      $display("FAIL areset_immediate: got %h sel %0d want 0", got, bus.sel);
    end
    #2 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(4'b1111, 1'b0, 1'b0);
      e = exp_q.pop_front(); got = observe(); checks++;
      if (got !== e || (i == 0 && got.grant !== 4'b0001)) begin
        errors++;
        $display("FAIL areset_post cyc %0d: got %h want %h", i, got, e);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_grant();
    test_fairness();
    test_freeze();
    test_owner_drop();
    test_single();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
# display_scheduler

Time-shares the board's 8-digit seven-segment display between up to four 32-bit debug sources: PC, instruction, ALU result and a register-file read port. Each requesting source owns the display for a programmable hold period, then ownership passes round-robin to the next requester. The block sits between the CPU debug taps and the display driver's `data_to_show` input, and reports which source is shown so that LEDs can label it.

## Interface
- `NUM_SRC`, 4: number of sources. Fixed at 4 in this revision.
- `HOLD_CYCLES`, 100_000_000: clk cycles a granted source is held (1 s at 100 MHz). Must be ≥ 2.
- `CNT_W`, 32: width of the hold counter. Must satisfy 2^CNT_W > HOLD_CYCLES.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `src_data`  in  32*NUM_SRC  packed source words; source i occupies [32*i+31 : 32*i].
- `src_req`  in  NUM_SRC  level request, one per source.
- `freeze`  in  1  holds the current owner and stops the hold counter.
- `skip`  in  1  single-cycle pulse (debounced button) that ends the current hold early.
- `data_to_show`  out  32  word sent to the display driver.
- `grant`  out  NUM_SRC  one-hot current owner; all zero when no owner.
- `sel`  out  2  index of the current owner; its value is meaningful only when `grant != 0`.
- `switched`  out  1  one-cycle pulse in the cycle after ownership changes.

## Operation
- States: IDLE, HOLD.
- Reset values: state = IDLE, `grant` = 0, `sel` = 0, `data_to_show` = 0, `switched` = 0, hold counter = 0, round-robin pointer `last` = NUM_SRC-1.
- **IDLE**
  - When `src_req` == 0: stay in IDLE. `data_to_show` keeps its last value (0 after reset).
  - When `src_req` != 0: pick the first requesting index, searching from `last`+1 upward modulo NUM_SRC. Then load `grant`/`sel`, set `last` to the winner, clear the counter, pulse `switched`, and go to HOLD.
- **HOLD**
  - The counter increments each cycle unless `freeze` is high.
  - A rotation event is any of the following:
    - counter == HOLD_CYCLES-1;
    - `skip` high;
    - the owner's `src_req` is low.
  - On a rotation event, re-arbitrate with the same search.
    - If another requester wins: switch to it, clear the counter and pulse `switched`.
    - If only the current owner is requesting: keep the grant and clear the counter. No `switched` pulse.
    - If no requester remains: clear `grant` and go to IDLE.
  - `freeze` suppresses expiry and `skip`. It does not suppress a dropped owner request, which still causes an immediate rotation.
- `data_to_show` is registered. Each cycle it loads the current owner's word, so live values track with a one-cycle delay.
- Round-robin fairness: with all requests high, grants cycle 0,1,2,3,0,…

## Timing
- Request to grant: `src_req` rising in IDLE at edge n gives `grant` valid after edge n+1, and `data_to_show` valid after edge n+2.
- Hold length: a grant lasts exactly HOLD_CYCLES cycles when `freeze` is low and there are no interruptions.
- Hold with freeze: frozen cycles extend the hold one-for-one.
- `skip` in HOLD: the new grant appears on the next edge.
- `skip` in IDLE: ignored.
- Simultaneous `skip` and expiry: a single rotation occurs.
- Counter wrap: the counter never passes HOLD_CYCLES-1.
- `rst` asserted at any time clears all state asynchronously. The first arbitration after release starts from index 0.

## Structure
- Package `display_pkg`:
  - `NUM_SRC`;
  - source index constants `SRC_PC` = 0, `SRC_INSTR` = 1, `SRC_ALU` = 2, `SRC_REG` = 3;
  - the state enum.
- Sub-module `rr_pick`: purely combinational. Inputs are `req[NUM_SRC-1:0]` and `last[1:0]`. Outputs are `any`, `idx[1:0]` and `onehot`. It is instantiated once and used both by IDLE entry and by HOLD rotation.

## Test plan
1. **Reset and first grant.** HOLD_CYCLES = 4, `rst` pulse, then `src_req` = 4'b0101 with src0 = 0x1111_1111 and src2 = 0x2222_2222.
   - `grant` = 0001 one edge after the request.
   - Four cycles later `grant` = 0100.
   - Four cycles after that `grant` = 0001.
   - `data_to_show` follows each grant one cycle later.
2. **Full fairness.** `src_req` = 1111 for 40 cycles at HOLD_CYCLES = 4.
   - Grant sequence is 0,1,2,3,0,… with each grant held exactly 4 cycles.
   - `switched` pulses 10 times.
3. **Freeze.** Assert `freeze` for 10 cycles mid-hold.
   - The grant is held 14 cycles in total.
   - `skip` pulses during the freeze have no effect.
4. **Owner drops.** Owner 1 lowers its request at hold cycle 1 with `freeze` high.
   - Grant moves to the next requester on the next edge.
   - If no other requester exists: `grant` = 0, the state returns to IDLE, and `data_to_show` keeps the last value.
5. **Single requester.** `src_req` = 0010 only.
   - The grant stays 0010 indefinitely, the counter restarts every 4 cycles, and `switched` never pulses after the first grant.
6. **Async reset mid-hold.** Assert `rst` between clock edges.
   - Outputs go to 0 immediately.
   - After release with `src_req` = 1111, the first grant is source 0.
